dmem_store_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 23 ++
 rtl/store_buffer_fifo.sv | 67 ++++++
 rtl/dmem_store_responder.sv | 94 +++++++++
 tb/tb_dmem_store_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory store responder and its store buffer.
package dmem_pkg;

    localparam int         WIDX_W  = 30;
    localparam logic [3:0] BE_FULL = 4'hF;

    typedef struct packed {
        logic [WIDX_W-1:0] word_idx;
        logic [31:0]       wdata;
        logic [3:0]        be;
    } sb_entry_t;

    function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular FIFO of posted stores with an associative lookup that reports the
// newest entry holding a given word index.
module store_buffer_fifo
    import dmem_pkg::*;
#(
    parameter  int SB_DEPTH = 4,
    localparam int PTR_W    = $clog2(SB_DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  sb_entry_t         push_entry_i,
    input  logic              pop_i,
    input  logic [WIDX_W-1:0] lookup_idx_i,
    output sb_entry_t         head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              match_o,
    output sb_entry_t         youngest_o
);

    sb_entry_t        ent_q [SB_DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q;
    logic [PTR_W-1:0] slot;

    assign count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            if (push_i) tail_q <= tail_q + PTR_W'(1);
            if (pop_i)  head_q <= head_q + PTR_W'(1);
            count_q <= count_d;
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) ent_q[tail_q] <= push_entry_i;
    end

    // Walk oldest to newest so the last hit is the youngest matching store.
    always_comb begin
        match_o    = 1'b0;
        youngest_o = '0;
        slot       = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            slot = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && ent_q[slot].word_idx == lookup_idx_i) begin
                match_o    = 1'b1;
                youngest_o = ent_q[slot];
            end
        end
    end

    assign head_o  = ent_q[head_q];
    assign count_o = count_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/dmem_store_responder.sv
// Memory-side load/store responder: posted store buffer with forwarding in front
// of a single-port word RAM that absorbs buffered stores in otherwise idle cycles.
module dmem_store_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int SB_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        sb_empty
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    logic [WIDX_W-1:0] word_idx;
    logic              in_range, full, hazard, accept, push, pop, match;
    sb_entry_t         head, youngest, push_entry;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  head_idx;
    logic [31:0]       load_data;
    logic [31:0]       ram_q [DEPTH_WORDS];
    logic              rsp_valid_q, rsp_err_q;
    logic [31:0]       rsp_rdata_q;
    logic              unused_bits;

    assign word_idx   = req_addr[31:2];
    assign in_range   = word_idx < WIDX_W'(DEPTH_WORDS);
    assign full       = (count == CNT_W'(SB_DEPTH));
    assign hazard     = match && (youngest.be != BE_FULL);
    assign push_entry = '{word_idx: word_idx, wdata: req_wdata, be: req_be};
    assign head_idx   = head.word_idx[IDX_W-1:0];
    assign unused_bits = ^{req_addr[1:0], head.word_idx[WIDX_W-1:IDX_W]};

    always_comb begin
        req_ready = 1'b0;
        if (reset) req_ready = req_write ? !full : !hazard;
    end

    assign accept = req_valid && req_ready;
    assign push   = accept && req_write && in_range;
    // Draining only in cycles the processor leaves unused keeps the RAM single-ported.
    assign pop    = reset && !accept && (count != '0);

    store_buffer_fifo #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .lookup_idx_i (word_idx),
        .head_o       (head),
        .count_o      (count),
        .empty_o      (sb_empty),
        .match_o      (match),
        .youngest_o   (youngest)
    );

    always_comb begin
        load_data = '0;
        if (in_range) load_data = match ? youngest.wdata : ram_q[word_idx[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (pop) ram_q[head_idx] <= apply_be(ram_q[head_idx], head.wdata, head.be);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= accept && !req_write;
            rsp_err_q   <= accept && !in_range;
            if (accept && !req_write) rsp_rdata_q <= load_data;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_store_responder.sv
// Bench for dmem_store_responder: directed vector table, hand-built corner
// sequences and a random mix checked against a program-order memory model.
module tb_dmem_store_responder;

    localparam int DEPTH_WORDS = 64;
    localparam int SB_DEPTH    = 4;
    localparam int NV          = 14;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err, sb_empty;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH_WORDS];
    logic [31:0] snap_mem  [DEPTH_WORDS];
    logic [31:0] last_rdata = '0;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
    } vec_t;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    dmem_store_responder #(.DEPTH_WORDS(DEPTH_WORDS), .SB_DEPTH(SB_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sb_empty  (sb_empty)
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int idx;
        idx = int'(a[31:2]);
        if (idx < DEPTH_WORDS) model_mem[idx] = merge(model_mem[idx], d, be);
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a);
        int idx;
        idx = int'(a[31:2]);
        return (idx < DEPTH_WORDS) ? model_mem[idx] : 32'h0;
    endfunction

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for acceptance, return at edge+1.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int stalls);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        stalls    = 0;
        @(negedge clk);
        while (!req_ready) begin
            stalls++;
            if (stalls > 64) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout addr=%h actual=stalled required=accepted", a);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic ev, input logic [31:0] ed,
                             input logic ee);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(ev));
        chk({tag, "_rdata"}, rsp_rdata, ed);
        chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
    endtask

    task automatic do_op(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, output int stalls);
        logic [31:0] ed;
        logic        ee;
        ee = int'(a[31:2]) >= DEPTH_WORDS;
        if (w) begin
            model_store(a, d, be);
            ed = last_rdata;
        end else begin
            ed = model_load(a);
            last_rdata = ed;
        end
        issue(w, a, d, be, stalls);
        check_rsp(tag, !w, ed, ee);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int r, widx;
        logic w;

        vecs[0]  = '{1'b1, 32'd100, 32'd25,        4'hF, 1'b0, 32'd0,         1'b0};
        vecs[1]  = '{1'b0, 32'd100, 32'd0,         4'h0, 1'b1, 32'd25,        1'b0};
        vecs[2]  = '{1'b1, 32'd100, 32'd1,         4'hF, 1'b0, 32'd25,        1'b0};
        vecs[3]  = '{1'b1, 32'd100, 32'd2,         4'hF, 1'b0, 32'd25,        1'b0};
        vecs[4]  = '{1'b0, 32'd100, 32'd0,         4'h0, 1'b1, 32'd2,         1'b0};
        vecs[5]  = '{1'b0, 32'd256, 32'd0,         4'h0, 1'b1, 32'd0,         1'b1};
        vecs[6]  = '{1'b1, 32'd256, 32'hDEADBEEF,  4'hF, 1'b0, 32'd0,         1'b1};
        vecs[7]  = '{1'b0, 32'd252, 32'd0,         4'h0, 1'b1, 32'h10003F3F,  1'b0};
        vecs[8]  = '{1'b1, 32'd248, 32'h0000BEEF,  4'h3, 1'b0, 32'h10003F3F,  1'b0};
        vecs[9]  = '{1'b0, 32'd248, 32'd0,         4'h0, 1'b1, 32'h1000BEEF,  1'b0};
        vecs[10] = '{1'b0, 32'd0,   32'd0,         4'h0, 1'b1, 32'h10000000,  1'b0};
        vecs[11] = '{1'b1, 32'd4,   32'h55000000,  4'h8, 1'b0, 32'h10000000,  1'b0};
        vecs[12] = '{1'b0, 32'd4,   32'd0,         4'h0, 1'b1, 32'h55000101,  1'b0};
        vecs[13] = '{1'b0, 32'd260, 32'd0,         4'h0, 1'b1, 32'd0,         1'b1};

        // Reset state, with a load presented during reset.
        req_valid = 1'b1;
        req_write = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_sb_empty", 32'(sb_empty), 32'd1);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;

        // Give every RAM word a known value.
        for (int i = 0; i < DEPTH_WORDS; i++) do_op("preload", 1'b1, 32'(i * 4), init_val(i), 4'hF, st);
        idle(8);
        chk("preload_sb_empty", 32'(sb_empty), 32'd1);

        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].be, st);
            check_rsp($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ee);
            if (vecs[i].w) model_store(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            else last_rdata = vecs[i].ed;
        end

        // Forwarded data later read back from RAM after drain.
        idle(8);
        chk("drain_sb_empty", 32'(sb_empty), 32'd1);
        do_op("ram_read100", 1'b0, 32'd100, 32'd0, 4'h0, st);
        chk("ram_read100_value", rsp_rdata, 32'd2);

        // Full buffer: fifth back-to-back store stalls exactly one cycle.
        for (int k = 0; k < 5; k++) begin
            do_op($sformatf("full_st%0d", k), 1'b1, 32'(k * 4), 32'(k + 1), 4'hF, st);
            chk($sformatf("full_stalls%0d", k), 32'(st), (k == 4) ? 32'd1 : 32'd0);
        end
        idle(8);
        for (int k = 0; k < 5; k++) begin
            do_op($sformatf("full_ld%0d", k), 1'b0, 32'(k * 4), 32'd0, 4'h0, st);
            chk($sformatf("full_ldval%0d", k), rsp_rdata, 32'(k + 1));
        end

        // Partial-overlap hazard: load waits for the partial store to drain.
        do_op("haz_st_full", 1'b1, 32'd96, 32'h11223344, 4'hF, st);
        idle(6);
        do_op("haz_st_part", 1'b1, 32'd96, 32'h000000AA, 4'h1, st);
        do_op("haz_ld", 1'b0, 32'd96, 32'd0, 4'h0, st);
        chk("haz_stalls", 32'(st), 32'd1);
        chk("haz_value", rsp_rdata, 32'h112233AA);

        // Reset with three stores still buffered discards them.
        idle(8);
        snap_mem = model_mem;
        do_op("rst_st0", 1'b1, 32'd20, 32'hAAAA0001, 4'hF, st);
        do_op("rst_st1", 1'b1, 32'd24, 32'hAAAA0002, 4'hF, st);
        do_op("rst_st2", 1'b1, 32'd28, 32'hAAAA0003, 4'hF, st);
        do_op("rst_ld", 1'b0, 32'd200, 32'd0, 4'h0, st);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'd200;
        reset     = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_pre_sb_empty", 32'(sb_empty), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_sb_empty", 32'(sb_empty), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;
        reset = 1'b1;
        model_mem = snap_mem;
        last_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            do_op($sformatf("rst_chk%0d", k), 1'b0, 32'(20 + k * 4), 32'd0, 4'h0, st);
            chk($sformatf("rst_old%0d", k), rsp_rdata, init_val(5 + k));
        end

        // Random mix on a few hot words plus out-of-range addresses.
        for (int n = 0; n < 300; n++) begin
            r    = int'($urandom_range(0, 15));
            widx = (r < 10) ? r : 54 + r;
            w    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            do_op($sformatf("rnd%0d", n), w, 32'(widx * 4) | 32'($urandom_range(0, 3)),
                  $urandom, 4'($urandom_range(1, 15)), st);
        end

        idle(8);
        chk("final_sb_empty", 32'(sb_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
